// File: rtl/operand_fwd_unit.sv
// Operand forwarding unit for a short in-order pipeline.
// Tracks the two most recent register writers (M = EX/MEM, W = MEM/WB)
// and selects, per source channel, the newest available value for the
// instruction in EX. A load sitting in M cannot forward yet, so a read of
// its destination raises a one-cycle load-use stall.
//
// Handshake: there is no valid/ready pair on this block. ex_valid qualifies
// the EX writer each cycle; hazard_stall is a request back to the pipeline
// that EX must be held and replayed next cycle; freeze holds everything.
module operand_fwd_unit #(
    parameter int DW      = 16,
    parameter int AW      = 4,
    parameter int NPORT   = 2,
    parameter int R0_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  freeze,
    input  logic                  ex_valid,
    input  logic [AW-1:0]         ex_rd,
    input  logic [DW-1:0]         ex_result,
    input  logic                  ex_is_load,
    input  logic [DW-1:0]         mem_load_data,
    input  logic [NPORT*AW-1:0]   ex_rs,
    input  logic [NPORT*DW-1:0]   ex_rf_data,
    output logic [NPORT*DW-1:0]   op_out,
    output logic [NPORT*2-1:0]    fwd_sel,
    output logic                  hazard_stall,
    output logic [15:0]           stall_cnt
);

    // M entry (EX/MEM)
    logic          m_valid_q, m_valid_d;
    logic [AW-1:0] m_rd_q;
    logic [DW-1:0] m_data_q;
    logic          m_is_load_q;

    // W entry (MEM/WB)
    logic          w_valid_q, w_valid_d;
    logic [AW-1:0] w_rd_q;
    logic [DW-1:0] w_data_q, w_data_d;

    logic [15:0]      stall_cnt_q, stall_cnt_d;
    logic [NPORT-1:0] m_hit;
    logic [NPORT-1:0] w_hit;
    logic             rd_ok;

    // Per-channel entry matching; register 0 never matches when hardwired.
    always_comb begin
        m_hit = '0;
        w_hit = '0;
        for (int k = 0; k < NPORT; k++) begin
            if ((R0_ZERO == 0) || (ex_rs[k*AW +: AW] != '0)) begin
                m_hit[k] = m_valid_q && (m_rd_q == ex_rs[k*AW +: AW]);
                w_hit[k] = w_valid_q && (w_rd_q == ex_rs[k*AW +: AW]);
            end
        end
    end

    // Operand mux: M (non-load) beats W beats the register file.
    always_comb begin
        op_out  = ex_rf_data;
        fwd_sel = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (m_hit[k] && !m_is_load_q) begin
                op_out[k*DW +: DW] = m_data_q;
                fwd_sel[k*2 +: 2]  = 2'b10;
            end else if (w_hit[k]) begin
                op_out[k*DW +: DW] = w_data_q;
                fwd_sel[k*2 +: 2]  = 2'b01;
            end
        end
    end

    // Load-use detection and next-state values for the tracking entries.
    always_comb begin
        hazard_stall = (|m_hit) && m_is_load_q && !freeze;
        rd_ok        = (R0_ZERO == 0) || (ex_rd != '0);
        // A stalled EX instruction is replayed, so it must not enter M now.
        m_valid_d    = ex_valid && !hazard_stall && rd_ok;
        w_valid_d    = m_valid_q;
        w_data_d     = m_is_load_q ? mem_load_data : m_data_q;
        stall_cnt_d  = stall_cnt_q;
        if (hazard_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Valid bits and stall counter: reset clears, freeze holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q   <= 1'b0;
            w_valid_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else if (!freeze) begin
            m_valid_q   <= m_valid_d;
            w_valid_q   <= w_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Entry payloads are only meaningful alongside a set valid bit.
    always_ff @(posedge clk) begin
        if (!freeze) begin
            m_rd_q      <= ex_rd;
            m_data_q    <= ex_result;
            m_is_load_q <= ex_is_load;
            w_rd_q      <= m_rd_q;
            w_data_q    <= w_data_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
